adder_4b: RTL and testbench

- Registered 4-bit ripple-carry binary adder with carry-in and carry-out.
- Built from four one-bit full-adder stages chained through the carry.
- Result is captured in an output register on the rising clock edge.
- Used as the basic arithmetic leaf for small datapaths and for exhaustive-sweep regression.

---
 rtl/adder_4b.sv | 58 +++++
 tb/tb_adder_4b.sv | 135 +++++++++++++
 2 files changed

// File: rtl/adder_4b.sv
// Registered 4-bit ripple-carry adder: four full-adder stages
// chained through the carry, result captured on the rising edge.

module adder_4b_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);

   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module adder_4b (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] S,
   output logic       C4
);

   logic [4:0] w_c;
   logic [3:0] w_s;
   logic [3:0] r_s;
   logic       r_c4;

   assign w_c[0] = c_in;

   // Carry ripples from stage 0 up to stage 3.
   for (genvar i = 0; i < 4; i++) begin : g_stage
      adder_4b_fa u_fa (
         .i_a (a[i]),
         .i_b (b[i]),
         .i_c (w_c[i]),
         .o_s (w_s[i]),
         .o_c (w_c[i+1])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s  <= 4'h0;
         r_c4 <= 1'b0;
      end else begin
         r_s  <= w_s;
         r_c4 <= w_c[4];
      end
   end

   assign S  = r_s;
   assign C4 = r_c4;

endmodule

// File: tb/tb_adder_4b.sv
// Self-checking bench for adder_4b: vector table, exhaustive
// sweeps with a result queue, and asynchronous reset corners.

module tb_adder_4b;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       c_in;
   logic [3:0] S;
   logic       C4;

   int checks;
   int errors;

   logic [4:0] q[$];

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      logic [3:0] s;
      logic       c4;
   } vec_t;

   vec_t vecs[8];

   adder_4b dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .c_in (c_in),
      .S    (S),
      .C4   (C4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [4:0] exp);
      checks++;
      if ({C4, S} !== exp) begin
         errors++;
         $display("FAIL %s: got C4=%0b S=%h, want C4=%0b S=%h",
                  name, C4, S, exp[4], exp[3:0]);
      end
   endtask

   // Drive one operand set, push its expected result, compare after the edge.
   task automatic step(input logic [3:0] ta, input logic [3:0] tb,
                       input logic tc, input logic [4:0] exp,
                       input string name);
      logic [4:0] e;
      a    = ta;
      b    = tb;
      c_in = tc;
      q.push_back(exp);
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk(name, e);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      vecs[0] = '{4'h9, 4'h8, 1'b0, 4'h1, 1'b1};
      vecs[1] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0};
      vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
      vecs[3] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
      vecs[4] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0};
      vecs[5] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0};
      vecs[6] = '{4'hA, 4'hA, 1'b1, 4'h5, 1'b1};
      vecs[7] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};

      rst  = 1'b1;
      a    = 4'hF;
      b    = 4'hF;
      c_in = 1'b1;
      #1;
      chk("reset_async", 5'h00);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("reset_hold", 5'h00);
      end
      rst = 1'b0;
      #1;
      chk("reset_release_no_edge", 5'h00);
      step(4'hF, 4'hF, 1'b1, 5'h1F, "first_after_reset");

      // Consecutive table entries also exercise 1-cycle latency and throughput.
      for (int i = 0; i < 8; i++)
         step(vecs[i].a, vecs[i].b, vecs[i].c,
              {vecs[i].c4, vecs[i].s}, $sformatf("vec%0d", i));

      // Inputs changing between edges must not reach the outputs.
      a = 4'hF;
      b = 4'h1;
      #2;
      chk("mid_cycle_input", 5'h00);

      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 256; i++) begin
            logic [3:0] ta;
            logic [3:0] tb;
            ta = 4'(i >> 4);
            tb = 4'(i);
            step(ta, tb, 1'(c),
                 5'(int'(ta) + int'(tb) + c),
                 $sformatf("sweep_c%0d_%0d_%0d", c, ta, tb));
            if (c == 1 && i == 100) begin
               #1;
               rst = 1'b1;
               #1;
               chk("midrun_rst_async", 5'h00);
               @(posedge clk);
               #1;
               chk("midrun_rst_edge", 5'h00);
               #2;
               rst = 1'b0;
               #1;
               chk("midrun_rst_release", 5'h00);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
